// File: rtl/acq_pkg.sv
// Shared sizing helpers, default geometry and fetch FSM states for the
// acquisition packer and its word RAM.
package acq_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int SAMPLE_W_DEF   = 12;
    localparam int SPW_DEF        = 4;
    localparam int OUT_W_DEF      = 16;
    localparam int DEPTH_LOG2_DEF = 9;

    localparam int WORD_W = SAMPLE_W_DEF * SPW_DEF;
    localparam int BEATS  = WORD_W / OUT_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } fetch_state_t;

endpackage

// File: rtl/acq_sdp_ram.sv
// Simple dual-port word store: one write port, one registered read port
// with single-cycle latency. The array is intentionally not reset.
module acq_sdp_ram
    import acq_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int AW    = DEPTH_LOG2_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/acq_packer.sv
// Packs strobed ADC samples into words, buffers them in a RAM FIFO and
// streams each word out MSB-beat first over a valid/ready handshake.
module acq_packer
    import acq_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int SPW        = SPW_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                begin_acq,
    input  logic                wr_clk,
    input  logic [SAMPLE_W-1:0] data_in,
    output logic [OUT_W-1:0]    data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                BRAM_empty,
    output logic                full,
    output logic                overflow,
    output logic [DEPTH_LOG2:0] level
);

    localparam int WORD_BITS = SAMPLE_W * SPW;
    localparam int NUM_BEATS = WORD_BITS / OUT_W;
    localparam int LANE_W    = (SPW > 1) ? clog2(SPW) : 1;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? clog2(NUM_BEATS) : 1;

    localparam logic [LANE_W-1:0]     LAST_LANE   = LANE_W'(SPW - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(NUM_BEATS - 1);
    localparam logic [DEPTH_LOG2:0]   DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);

    fetch_state_t state, next_state;

    logic                  d_wr;
    logic                  strobe_edge;
    logic                  commit_pend;
    logic                  wr_en;
    logic                  fetch;
    logic                  load;
    logic                  accept;
    logic [LANE_W-1:0]     lane;
    logic [BEAT_W-1:0]     beat;
    logic [WORD_BITS-1:0]  word_buf;
    logic [WORD_BITS-1:0]  ram_rd;
    logic [WORD_BITS-1:0]  shift;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_next;

    assign strobe_edge = wr_clk & ~d_wr & begin_acq;
    assign wr_en       = commit_pend & ~full & begin_acq;
    assign data_out    = shift[WORD_BITS-1 -: OUT_W];
    assign out_valid   = (state == SEND);

    // The completed word sits in word_buf for one cycle and is committed on
    // the following edge; strobes are at least two cycles apart so it is stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_wr        <= 1'b0;
            lane        <= '0;
            commit_pend <= 1'b0;
        end else if (!begin_acq) begin
            d_wr        <= 1'b0;
            lane        <= '0;
            commit_pend <= 1'b0;
        end else begin
            d_wr        <= wr_clk;
            commit_pend <= strobe_edge && (lane == LAST_LANE);
            if (strobe_edge) begin
                lane <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (strobe_edge) begin
            for (int i = 0; i < SPW; i++) begin
                if (lane == LANE_W'(i)) begin
                    word_buf[WORD_BITS-1-i*SAMPLE_W -: SAMPLE_W] <= data_in;
                end
            end
        end
    end

    always_comb begin
        level_next = level;
        case ({wr_en, fetch})
            2'b10:   level_next = level + LEVEL_ONE;
            2'b01:   level_next = level - LEVEL_ONE;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            BRAM_empty <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else if (!begin_acq) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            BRAM_empty <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level      <= level_next;
            BRAM_empty <= (level_next == '0);
            full       <= (level_next == DEPTH_WORDS);
            if (commit_pend && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A read is issued from IDLE or straight off the last accepted beat, so
    // back-to-back words cost one bubble cycle for the RAM latency.
    always_comb begin
        next_state = state;
        fetch      = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    fetch      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                load       = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    accept = 1'b1;
                    if (beat == LAST_BEAT) begin
                        if (level != '0) begin
                            fetch      = 1'b1;
                            next_state = WAIT;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (!begin_acq) begin
            next_state = IDLE;
            fetch      = 1'b0;
            load       = 1'b0;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            beat  <= '0;
        end else if (!begin_acq) begin
            shift <= '0;
            beat  <= '0;
        end else if (load) begin
            shift <= ram_rd;
            beat  <= '0;
        end else if (accept) begin
            shift <= shift << OUT_W;
            beat  <= beat + BEAT_W'(1);
        end
    end

    acq_sdp_ram #(
        .WIDTH (WORD_BITS),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk (clk),
        .we  (wr_en),
        .wa  (wr_ptr),
        .wd  (word_buf),
        .re  (fetch),
        .ra  (rd_ptr),
        .rd  (ram_rd)
    );

endmodule

// File: tb/tb_acq_packer.sv
// Directed bench for acq_packer with a 4-word FIFO: packing, backpressure,
// fill/overflow, commit-during-fetch, flush and asynchronous reset.
module tb_acq_packer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        begin_acq = 1'b1;
    logic        wr_clk    = 1'b0;
    logic [11:0] data_in   = '0;
    logic        out_ready = 1'b1;
    logic [15:0] data_out;
    logic        out_valid;
    logic        BRAM_empty;
    logic        full;
    logic        overflow;
    logic [2:0]  level;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [47:0] fill_words [6] = '{
        48'h1001_2001_3001, 48'h1002_2002_3002, 48'h1003_2003_3003,
        48'h1004_2004_3004, 48'h1005_2005_3005, 48'h1006_2006_3006
    };
    logic [47:0] cur_word;

    acq_packer #(
        .SAMPLE_W   (12),
        .SPW        (4),
        .OUT_W      (16),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .begin_acq  (begin_acq),
        .wr_clk     (wr_clk),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .BRAM_empty (BRAM_empty),
        .full       (full),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One strobe: wr_clk high for one cycle then low, returning at the
    // negedge just after the capturing clock edge.
    task automatic applyStimulus(input logic [11:0] sample);
        @(negedge clk);
        data_in = sample;
        wr_clk  = 1'b1;
        @(negedge clk);
        wr_clk  = 1'b0;
    endtask

    task automatic sendWord(input logic [47:0] w);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w[47-12*i -: 12]);
        end
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(out_valid), 1);
    endtask

    task automatic waitBeat(input string tag, input logic [15:0] exp);
        int n = 0;
        while (!(out_valid && out_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_vld"}, 32'(out_valid), 1);
        checkOutput(tag, 32'(data_out), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_empty", 32'(BRAM_empty), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_ovf", 32'(overflow), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_data", 32'(data_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic pack with exact first-beat latency
        out_ready = 1'b1;
        sendWord(48'hABC_DEF_123_456);
        @(negedge clk);
        checkOutput("basic_lvl1", 32'(level), 1);
        checkOutput("basic_notempty", 32'(BRAM_empty), 0);
        @(negedge clk);
        checkOutput("basic_rd_valid", 32'(out_valid), 0);
        checkOutput("basic_rd_level", 32'(level), 0);
        checkOutput("basic_rd_empty", 32'(BRAM_empty), 1);
        @(negedge clk);
        checkOutput("basic_first_vld", 32'(out_valid), 1);
        checkOutput("basic_first_data", 32'(data_out), 'hABCD);
        waitBeat("basic_b0", 16'hABCD);
        waitBeat("basic_b1", 16'hEF12);
        waitBeat("basic_b2", 16'h3456);
        checkOutput("basic_idle_vld", 32'(out_valid), 0);
        checkOutput("basic_idle_empty", 32'(BRAM_empty), 1);

        // backpressure on beat 1
        out_ready = 1'b0;
        sendWord(48'hABC_DEF_123_456);
        waitValid("bp_valid");
        checkOutput("bp_b0_hold", 32'(data_out), 'hABCD);
        out_ready = 1'b1;
        waitBeat("bp_b0", 16'hABCD);
        out_ready = 1'b0;
        repeat (5) begin
            checkOutput("bp_hold_data", 32'(data_out), 'hEF12);
            checkOutput("bp_hold_vld", 32'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        waitBeat("bp_b1", 16'hEF12);
        waitBeat("bp_b2", 16'h3456);
        checkOutput("bp_end_vld", 32'(out_valid), 0);

        // fill and overflow: the first word moves into the output stage,
        // the next four fill the RAM and the sixth is dropped
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sendWord(fill_words[k]);
        end
        @(negedge clk);
        checkOutput("fill_level", 32'(level), 4);
        checkOutput("fill_full", 32'(full), 1);
        checkOutput("fill_no_ovf", 32'(overflow), 0);
        sendWord(fill_words[5]);
        @(negedge clk);
        checkOutput("ovf_set", 32'(overflow), 1);
        checkOutput("ovf_level", 32'(level), 4);
        checkOutput("ovf_full", 32'(full), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cur_word = fill_words[k];
            waitBeat($sformatf("drain_w%0d_b0", k), cur_word[47:32]);
            waitBeat($sformatf("drain_w%0d_b1", k), cur_word[31:16]);
            waitBeat($sformatf("drain_w%0d_b2", k), cur_word[15:0]);
        end
        checkOutput("drain_vld", 32'(out_valid), 0);
        checkOutput("drain_empty", 32'(BRAM_empty), 1);
        checkOutput("drain_level", 32'(level), 0);
        checkOutput("drain_full", 32'(full), 0);
        checkOutput("drain_ovf_sticky", 32'(overflow), 1);

        // flush mid-word
        applyStimulus(12'h111);
        applyStimulus(12'h222);
        begin_acq = 1'b0;
        @(negedge clk);
        begin_acq = 1'b1;
        checkOutput("flush_ovf", 32'(overflow), 0);
        checkOutput("flush_level", 32'(level), 0);
        sendWord(48'hABC_DEF_123_456);
        waitBeat("flush_b0", 16'hABCD);
        waitBeat("flush_b1", 16'hEF12);
        waitBeat("flush_b2", 16'h3456);
        checkOutput("flush_end_vld", 32'(out_valid), 0);
        checkOutput("flush_end_empty", 32'(BRAM_empty), 1);

        // commit of word C lands on the same edge as the fetch of word B
        out_ready = 1'b0;
        sendWord(48'h5A5_A6B_6B7_C7C);
        sendWord(48'h012_345_678_9AB);
        applyStimulus(12'hFED);
        applyStimulus(12'hCBA);
        applyStimulus(12'h987);
        @(negedge clk);
        checkOutput("sim_pre_level", 32'(level), 1);
        checkOutput("sim_pre_vld", 32'(out_valid), 1);
        checkOutput("sim_a0", 32'(data_out), 'h5A5A);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("sim_a1", 32'(data_out), 'h6B6B);
        data_in = 12'h654;
        wr_clk  = 1'b1;
        @(negedge clk);
        checkOutput("sim_a2", 32'(data_out), 'h7C7C);
        wr_clk  = 1'b0;
        @(negedge clk);
        checkOutput("sim_level", 32'(level), 1);
        checkOutput("sim_wait_vld", 32'(out_valid), 0);
        waitBeat("sim_b0", 16'h0123);
        waitBeat("sim_b1", 16'h4567);
        waitBeat("sim_b2", 16'h89AB);
        waitBeat("sim_c0", 16'hFEDC);
        waitBeat("sim_c1", 16'hBA98);
        waitBeat("sim_c2", 16'h7654);
        checkOutput("sim_end_level", 32'(level), 0);
        checkOutput("sim_end_empty", 32'(BRAM_empty), 1);

        // asynchronous reset while a word is being sent and another is stored
        out_ready = 1'b0;
        sendWord(48'hABC_DEF_123_456);
        sendWord(48'h012_345_678_9AB);
        @(negedge clk);
        checkOutput("ar_pre_vld", 32'(out_valid), 1);
        checkOutput("ar_pre_level", 32'(level), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_vld", 32'(out_valid), 0);
        checkOutput("ar_level", 32'(level), 0);
        checkOutput("ar_empty", 32'(BRAM_empty), 1);
        checkOutput("ar_data", 32'(data_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
